branch_update_arbiter: RTL and testbench



---
 rtl/branch_update_arbiter_pkg.sv | 31 +++
 rtl/branch_update_arbiter_if.sv | 41 ++++
 rtl/branch_update_fifo.sv | 65 ++++++
 rtl/branch_update_arbiter.sv | 148 ++++++++++++++
 tb/tb_branch_update_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_update_arbiter_pkg.sv
// Shared types and helpers for the branch update arbiter.
// Defines the predictor update record, the default queue depth and the
// mispredict / redirect-target helper functions.
package branch_update_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        logic  outcome;
        word_t target;
    } bp_update_t;

    localparam int BP_UPD_DEPTH = 4;

    // A branch mispredicts on a wrong direction, or on a wrong target when taken.
    function automatic logic is_mispredict(input logic  outcome,
                                           input word_t target,
                                           input logic  pred_outcome,
                                           input word_t pred_target);
        return (outcome != pred_outcome) || (outcome && (target != pred_target));
    endfunction

    // Correct next PC: the taken target, or the fall-through (wraps at 2^32).
    function automatic word_t redirect_target(input word_t pc,
                                              input logic  outcome,
                                              input word_t target);
        return outcome ? target : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/branch_update_arbiter_if.sv
// Bus between the branch FU lanes / fetch / predictor and the arbiter.
// The slave modport is the arbiter; the master modport is its environment.
// drain_stall is a test hook that holds the queue from draining.
interface branch_update_arbiter_if
    import branch_update_arbiter_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    word_t [NREQ-1:0]          req_pc;
    logic [NREQ-1:0]           req_outcome;
    word_t [NREQ-1:0]          req_target;
    logic [NREQ-1:0]           req_pred_outcome;
    word_t [NREQ-1:0]          req_pred_target;
    logic                      drain_stall;
    logic                      update_btb;
    word_t                     update_pc;
    logic                      branch_outcome;
    word_t                     branch_target;
    logic                      redirect_valid;
    word_t                     redirect_pc;
    logic [15:0]               mispredict_cnt;
    logic [$clog2(DEPTH):0]    fifo_count;

    modport master (
        output req_valid, req_pc, req_outcome, req_target,
               req_pred_outcome, req_pred_target, drain_stall,
        input  req_ready, update_btb, update_pc, branch_outcome, branch_target,
               redirect_valid, redirect_pc, mispredict_cnt, fifo_count
    );

    modport slave (
        input  req_valid, req_pc, req_outcome, req_target,
               req_pred_outcome, req_pred_target, drain_stall,
        output req_ready, update_btb, update_pc, branch_outcome, branch_target,
               redirect_valid, redirect_pc, mispredict_cnt, fifo_count
    );

endinterface

// File: rtl/branch_update_fifo.sv
// Small FIFO of predictor update records with occupancy count.
// Pushes while full and pops while empty are ignored.
module branch_update_fifo
    import branch_update_arbiter_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  bp_update_t             din,
    input  logic                   pop,
    output bp_update_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    bp_update_t    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/branch_update_arbiter.sv
// Round-robin arbiter merging two branch FU lanes into the predictor update
// port, with mispredict redirect and a saturating mispredict counter.
// Optional macro BRANCH_UPD_FILTER_EN: correctly predicted not-taken results
// complete their handshake but are not forwarded to the predictor.
module branch_update_arbiter
    import branch_update_arbiter_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH,
    parameter int NREQ  = 2
) (
    input logic                    CLK,
    input logic                    nRST,
    branch_update_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NREQ-1:0] grant_s;
    logic            sel_s;
    logic            other_s;
    logic            accept_s;
    logic            mis_s;
    logic            enq_s;
    logic            bypass_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   count_s;
    bp_update_t      sel_upd_s;
    bp_update_t      head_s;

    logic            rr_ptr_r;
    logic            upd_valid_r;
    bp_update_t      upd_r;
    logic            redir_valid_r;
    word_t           redir_pc_r;
    logic [15:0]     mis_cnt_r;

    assign other_s = ~rr_ptr_r;

    // Grant the favoured lane if valid, otherwise the other valid lane
    always_comb begin
        grant_s = '0;
        sel_s   = rr_ptr_r;
        if (bus.req_valid[rr_ptr_r]) begin
            grant_s[rr_ptr_r] = 1'b1;
            sel_s             = rr_ptr_r;
        end else if (bus.req_valid[other_s]) begin
            grant_s[other_s] = 1'b1;
            sel_s            = other_s;
        end else begin
            grant_s = '0;
            sel_s   = rr_ptr_r;
        end
    end

    // Ready only for the granted lane while the queue has room
    always_comb begin
        if (full_s) begin
            bus.req_ready = '0;
        end else begin
            bus.req_ready = grant_s;
        end
    end

    assign accept_s  = (|grant_s) && !full_s;
    assign sel_upd_s = '{pc:      bus.req_pc[sel_s],
                         outcome: bus.req_outcome[sel_s],
                         target:  bus.req_target[sel_s]};
    assign mis_s     = is_mispredict(bus.req_outcome[sel_s], bus.req_target[sel_s],
                                     bus.req_pred_outcome[sel_s], bus.req_pred_target[sel_s]);

`ifdef BRANCH_UPD_FILTER_EN
    assign enq_s = bus.req_outcome[sel_s] || bus.req_pred_outcome[sel_s];
`else
    assign enq_s = 1'b1;
`endif

    // An empty, non-stalled queue forwards the new result straight to the port
    assign bypass_s = accept_s && enq_s && empty_s && !bus.drain_stall;
    assign push_s   = accept_s && enq_s && !bypass_s;
    assign pop_s    = !empty_s && !bus.drain_stall;

    branch_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (push_s),
        .din   (sel_upd_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Arbitration pointer moves to the lane that was not served
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_r <= 1'b0;
        end else if (accept_s) begin
            rr_ptr_r <= ~sel_s;
        end
    end

    // Redirect pulse, corrected next PC and saturating mispredict count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            mis_cnt_r     <= 16'd0;
        end else begin
            redir_valid_r <= accept_s && mis_s;
            if (accept_s && mis_s) begin
                redir_pc_r <= redirect_target(bus.req_pc[sel_s], bus.req_outcome[sel_s],
                                              bus.req_target[sel_s]);
                if (mis_cnt_r != 16'hFFFF) begin
                    mis_cnt_r <= mis_cnt_r + 16'd1;
                end
            end
        end
    end

    // Predictor update port: queue head first, else the bypassed result
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            upd_valid_r <= 1'b0;
            upd_r       <= '0;
        end else if (pop_s) begin
            upd_valid_r <= 1'b1;
            upd_r       <= head_s;
        end else if (bypass_s) begin
            upd_valid_r <= 1'b1;
            upd_r       <= sel_upd_s;
        end else begin
            upd_valid_r <= 1'b0;
        end
    end

    assign bus.update_btb     = upd_valid_r;
    assign bus.update_pc      = upd_r.pc;
    assign bus.branch_outcome = upd_r.outcome;
    assign bus.branch_target  = upd_r.target;
    assign bus.redirect_valid = redir_valid_r;
    assign bus.redirect_pc    = redir_pc_r;
    assign bus.mispredict_cnt = mis_cnt_r;
    assign bus.fifo_count     = count_s;

endmodule

// File: tb/tb_branch_update_arbiter.sv
// Directed bench for branch_update_arbiter with a queue-based reference model.
module tb_branch_update_arbiter;
    import branch_update_arbiter_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        word_t pc;
        logic  o;
        word_t t;
        logic  po;
        word_t pt;
    } item_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    branch_update_arbiter_if #(.DEPTH(DEPTH), .NREQ(2)) bus ();

    branch_update_arbiter #(.DEPTH(DEPTH), .NREQ(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    logic [1:0] last_ready;

    item_t lq0[$];
    item_t lq1[$];

    // reference model state
    int          m_rr;
    bp_update_t  m_q[$];
    logic        m_upd_v;
    bp_update_t  m_upd;
    logic        m_rv;
    word_t       m_rpc;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rr = 0;
        m_q.delete();
        m_upd_v = 1'b0;
        m_upd = '0;
        m_rv = 1'b0;
        m_rpc = 32'd0;
        m_cnt = 16'd0;
        lq0.delete();
        lq1.delete();
    endtask

    function automatic int model_grant();
        bit v [2];
        v[0] = (lq0.size() > 0);
        v[1] = (lq1.size() > 0);
        if (v[m_rr]) return m_rr;
        if (v[1 - m_rr]) return 1 - m_rr;
        return -1;
    endfunction

    function automatic logic [1:0] model_ready();
        int g;
        g = model_grant();
        if (g >= 0 && m_q.size() < DEPTH) return 2'(1 << g);
        return 2'b00;
    endfunction

    task automatic model_advance();
        int g;
        item_t it;
        g = model_grant();
        m_rv = 1'b0;
        if (g >= 0 && m_q.size() < DEPTH) begin
            if (g == 0) it = lq0.pop_front();
            else        it = lq1.pop_front();
            m_rr = 1 - g;
            if ((it.o != it.po) || (it.o && (it.t != it.pt))) begin
                m_rv  = 1'b1;
                m_rpc = it.o ? it.t : it.pc + 32'd4;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
`ifdef BRANCH_UPD_FILTER_EN
            if (it.o || it.po) m_q.push_back('{pc: it.pc, outcome: it.o, target: it.t});
`else
            m_q.push_back('{pc: it.pc, outcome: it.o, target: it.t});
`endif
        end
        if (!bus.drain_stall && m_q.size() > 0) begin
            m_upd   = m_q.pop_front();
            m_upd_v = 1'b1;
        end else begin
            m_upd_v = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        bus.req_valid = {lq1.size() > 0, lq0.size() > 0};
        if (lq0.size() > 0) begin
            bus.req_pc[0] = lq0[0].pc;  bus.req_outcome[0] = lq0[0].o;  bus.req_target[0] = lq0[0].t;
            bus.req_pred_outcome[0] = lq0[0].po;  bus.req_pred_target[0] = lq0[0].pt;
        end
        if (lq1.size() > 0) begin
            bus.req_pc[1] = lq1[0].pc;  bus.req_outcome[1] = lq1[0].o;  bus.req_target[1] = lq1[0].t;
            bus.req_pred_outcome[1] = lq1[0].po;  bus.req_pred_target[1] = lq1[0].pt;
        end
    endtask

    task automatic compare_outputs();
        if (bus.update_btb === 1'b1) upd_seen++;
        chk("update_btb",     32'(bus.update_btb),     32'(m_upd_v));
        chk("update_pc",      bus.update_pc,           m_upd.pc);
        chk("branch_outcome", 32'(bus.branch_outcome), 32'(m_upd.outcome));
        chk("branch_target",  bus.branch_target,       m_upd.target);
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
        chk("redirect_pc",    bus.redirect_pc,         m_rpc);
        chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_cnt));
        chk("fifo_count",     32'(bus.fifo_count),     32'(m_q.size()));
    endtask

    // One cycle: drive at negedge, check ready, advance model, check outputs
    task automatic tick();
        drive_inputs();
        #1;
        last_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(model_ready()));
        @(posedge CLK);
        model_advance();
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((lq0.size() > 0 || lq1.size() > 0 || m_q.size() > 0 || m_upd_v) && n < max) begin
            tick();
            n++;
        end
        chk("drain_budget", 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_clear();
        drive_inputs();
        @(posedge CLK);
        @(negedge CLK);
        compare_outputs();
        nRST = 1'b1;
    endtask

    function automatic item_t mk(input word_t pc, input logic o, input word_t t,
                                 input logic po, input word_t pt);
        item_t it;
        it.pc = pc; it.o = o; it.t = t; it.po = po; it.pt = pt;
        return it;
    endfunction

    initial begin
        bus.drain_stall = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_pc = '0; bus.req_outcome = 2'b00; bus.req_target = '0;
        bus.req_pred_outcome = 2'b00; bus.req_pred_target = '0;
        model_clear();
        @(negedge CLK);
        // reset state
        chk("rst_update_btb",  32'(bus.update_btb), 32'd0);
        chk("rst_redirect",    32'(bus.redirect_valid), 32'd0);
        chk("rst_cnt",         32'(bus.mispredict_cnt), 32'd0);
        chk("rst_fifo_count",  32'(bus.fifo_count), 32'd0);
        compare_outputs();
        nRST = 1'b1;

        // 1: backward taken, predicted not taken
        lq0.push_back(mk(32'h10, 1'b1, 32'h08, 1'b0, 32'h14));
        tick();
        chk("t1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("t1_redirect_pc",    bus.redirect_pc, 32'h08);
        chk("t1_update_btb",     32'(bus.update_btb), 32'd1);
        chk("t1_update_pc",      bus.update_pc, 32'h10);
        chk("t1_outcome",        32'(bus.branch_outcome), 32'd1);
        chk("t1_target",         bus.branch_target, 32'h08);
        chk("t1_cnt",            32'(bus.mispredict_cnt), 32'd1);
        tick();
        chk("t1_pulse_end",      32'(bus.redirect_valid), 32'd0);
        chk("t1_upd_end",        32'(bus.update_btb), 32'd0);
        chk("t1_upd_hold",       bus.update_pc, 32'h10);

        // 2: backward not taken, predicted taken
        lq0.push_back(mk(32'h10, 1'b0, 32'h08, 1'b1, 32'h08));
        tick();
        chk("t2_redirect_pc",    bus.redirect_pc, 32'h14);
        chk("t2_outcome",        32'(bus.branch_outcome), 32'd0);
        chk("t2_cnt",            32'(bus.mispredict_cnt), 32'd2);
        run_idle(10);

        // 3: both lanes valid, all correctly predicted
        do_reset();
        for (int k = 0; k < 2; k++) begin
            lq0.push_back(mk(32'h20, 1'b1, 32'h40, 1'b1, 32'h40));
            lq1.push_back(mk(32'h30, 1'b1, 32'h50, 1'b1, 32'h50));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_grant",   32'(last_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("t3_upd_pc",  bus.update_pc, (k % 2 == 0) ? 32'h20 : 32'h30);
            chk("t3_no_redir", 32'(bus.redirect_valid), 32'd0);
        end
        run_idle(10);

        // 4: fill to full with the drain stalled
        upd_seen = 0;
        bus.drain_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lq0.push_back(mk(32'h100 + 32'(4 * k), 1'b1, 32'h180, 1'b1, 32'h180));
            lq1.push_back(mk(32'h200 + 32'(4 * k), 1'b1, 32'h280, 1'b1, 32'h280));
        end
        for (int k = 0; k < 4; k++) tick();
        chk("t4_full_count", 32'(bus.fifo_count), 32'd4);
        tick();
        chk("t4_ready_full", 32'(last_ready), 32'd0);
        tick();
        chk("t4_still_full", 32'(bus.fifo_count), 32'd4);
        bus.drain_stall = 1'b0;
        run_idle(20);
        chk("t4_update_total", 32'(upd_seen), 32'd6);

        // 5: correct not-taken
        lq0.push_back(mk(32'h24, 1'b0, 32'h28, 1'b0, 32'h28));
        tick();
`ifdef BRANCH_UPD_FILTER_EN
        chk("t5_filtered_btb",   32'(bus.update_btb), 32'd0);
        chk("t5_filtered_count", 32'(bus.fifo_count), 32'd0);
`else
        chk("t5_update_btb", 32'(bus.update_btb), 32'd1);
        chk("t5_update_pc",  bus.update_pc, 32'h24);
        chk("t5_outcome",    32'(bus.branch_outcome), 32'd0);
`endif
        run_idle(10);

        // 6: reset while draining
        bus.drain_stall = 1'b1;
        for (int k = 0; k < 4; k++) lq0.push_back(mk(32'h300 + 32'(4 * k), 1'b1, 32'h3, 1'b0, 32'h0));
        for (int k = 0; k < 3; k++) tick();
        chk("t6_queued", 32'(bus.fifo_count), 32'd3);
        bus.drain_stall = 1'b0;
        tick();
        drive_inputs();
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_rst_btb",     32'(bus.update_btb), 32'd0);
        chk("t6_rst_pc",      bus.update_pc, 32'd0);
        chk("t6_rst_target",  bus.branch_target, 32'd0);
        chk("t6_rst_outcome", 32'(bus.branch_outcome), 32'd0);
        chk("t6_rst_redir",   32'(bus.redirect_valid), 32'd0);
        chk("t6_rst_rpc",     bus.redirect_pc, 32'd0);
        chk("t6_rst_cnt",     32'(bus.mispredict_cnt), 32'd0);
        chk("t6_rst_count",   32'(bus.fifo_count), 32'd0);
        model_clear();
        drive_inputs();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_stale", 32'(bus.update_btb), 32'd0);
        end

        // 7: back-to-back mispredicts, fall-through wrapping
        lq0.push_back(mk(32'h40, 1'b1, 32'h80, 1'b0, 32'h44));
        lq1.push_back(mk(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10));
        tick();
        chk("t7_first_rpc",  bus.redirect_pc, 32'h80);
        tick();
        chk("t7_second_rv",  32'(bus.redirect_valid), 32'd1);
        chk("t7_second_rpc", bus.redirect_pc, 32'h0);
        chk("t7_cnt",        32'(bus.mispredict_cnt), 32'd2);
        run_idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
